// File: rtl/seq_mult_pkg.sv
// seq_mult_pkg: shared state encoding and default operand width for the sequential multiplier
package seq_mult_pkg;
  localparam int DEFAULT_WIDTH = 4;
  typedef enum logic [1:0] {IDLE, LOAD, RUN, DONE} state_t;
endpackage

// File: rtl/mult_piso_shift.sv
// mult_piso_shift: parallel-in serial-out shifter feeding multiplier bits LSB first
// Ports: clk, reset (async active-low), sl (1=load d, 0=shift right), d[WIDTH], q (serial out)
module mult_piso_shift
  import seq_mult_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             sl,
  input  logic [WIDTH-1:0] d,
  output logic             q
);
  logic [WIDTH-1:0] sh_q, sh_d;
  always_comb sh_d = sl ? d : sh_q >> 1;
  always_ff @(posedge clk or negedge reset)
    if (!reset) sh_q <= '0;
    else sh_q <= sh_d;
  assign q = sh_q[0];
endmodule

// File: rtl/seq_mult_ctrl.sv
// seq_mult_ctrl: shift-and-add unsigned multiplier controlled by an IDLE/LOAD/RUN/DONE FSM
// Ports: clk, reset (async active-low), start, a, b -> busy, done (1-cycle pulse), product[2*WIDTH]
// Option: define SEQ_MULT_EARLY_EXIT_EN to finish RUN as soon as the remaining multiplier bits are zero
module seq_mult_ctrl
  import seq_mult_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] product
);
  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam int PW = 2 * WIDTH;
  state_t state_q, state_d;
  logic [WIDTH-1:0] mcand_q, mcand_d, mult_q, mult_d;
  logic [PW-1:0] acc_q, acc_d, prod_q, prod_d, addend;
  logic [CW-1:0] cnt_q, cnt_d;
  logic ser, last;
  mult_piso_shift #(.WIDTH(WIDTH)) u_shift (
    .clk  (clk),
    .reset(reset),
    .sl   (state_q == LOAD),
    .d    (mult_q),
    .q    (ser)
  );
  assign addend = PW'(mcand_q) << cnt_q;
`ifdef SEQ_MULT_EARLY_EXIT_EN
  // bits above the one being consumed now are all zero: nothing left to add
  assign last = (cnt_q == CW'(WIDTH - 1)) || (((mult_q >> cnt_q) >> 1) == '0);
`else
  assign last = cnt_q == CW'(WIDTH - 1);
`endif
  always_comb begin
    state_d = state_q;
    mcand_d = mcand_q;
    mult_d  = mult_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    prod_d  = prod_q;
    case (state_q)
      IDLE: if (start) begin
        state_d = LOAD;
        mcand_d = a;
        mult_d  = b;
      end
      LOAD: begin
        state_d = RUN;
        acc_d   = '0;
        cnt_d   = '0;
      end
      RUN: begin
        acc_d = acc_q + (ser ? addend : '0);
        cnt_d = cnt_q + 1'b1;
        if (last) begin
          state_d = DONE;
          prod_d  = acc_d;
        end
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      state_q <= IDLE;
      mcand_q <= '0;
      mult_q  <= '0;
      acc_q   <= '0;
      cnt_q   <= '0;
      prod_q  <= '0;
    end else begin
      state_q <= state_d;
      mcand_q <= mcand_d;
      mult_q  <= mult_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      prod_q  <= prod_d;
    end
  assign busy    = (state_q == LOAD) || (state_q == RUN);
  assign done    = state_q == DONE;
  assign product = prod_q;
endmodule

// File: doc/seq_mult_ctrl.md
SEQ_MULT_CTRL -- requirements
Module: seq_mult_ctrl

Interface
REQ-001 Parameter WIDTH, default 4, is the operand width in bits; the legal range is 2..16.
REQ-002 clk  input  1  is the single clock; all state changes on its rising edge.
REQ-003 reset  input  1  is the asynchronous, active-low reset.
REQ-004 start  input  1  is a one-cycle request to begin a multiplication.
REQ-005 a  input  WIDTH  is the multiplicand, unsigned.
REQ-006 b  input  WIDTH  is the multiplier, unsigned, consumed serially LSB-first.
REQ-007 busy  output  1  is high while an operation is in progress (LOAD or RUN state).
REQ-008 done  output  1  is a one-cycle pulse that marks product as valid.
REQ-009 product  output  2*WIDTH  is the unsigned result a*b.

Function
REQ-010 The state machine SHALL have four states: IDLE, LOAD, RUN and DONE.
REQ-011 Transitions SHALL be: IDLE to LOAD when start=1; LOAD to RUN unconditionally; RUN to DONE when the bit counter reaches WIDTH-1; DONE to IDLE unconditionally.
REQ-012 In IDLE, when start=1, a and b SHALL be sampled on the same edge into the multiplicand and multiplier registers.
REQ-013 In LOAD, the accumulator and bit counter SHALL be cleared to 0, and the serial shifter SHALL be parallel-loaded with b (load mode).
REQ-014 Each RUN cycle SHALL perform the following steps:
- if the shifter serial output is 1, add the multiplicand (zero-extended to 2*WIDTH, shifted left by the counter value) to the accumulator;
- shift the shifter right by one;
- increment the counter.
REQ-015 Accumulator width SHALL be 2*WIDTH and SHALL never overflow for unsigned operands.
REQ-016 The latency from the start edge to the done edge SHALL be WIDTH+2 cycles; done SHALL be high for exactly one cycle, in the DONE state.
REQ-017 product SHALL update only on entry to DONE and SHALL hold its value until the next DONE.
REQ-018 A start asserted while in LOAD, RUN or DONE SHALL be ignored, with no queuing.
REQ-019 A start asserted in the same cycle that DONE returns to IDLE SHALL be ignored; the next start is accepted only in IDLE.
REQ-020 Changes on a or b after the sampling edge SHALL NOT affect the operation in flight.

Reset
REQ-021 When reset=0, the block SHALL asynchronously force:
- state to IDLE;
- busy=0, done=0, product=0;
- accumulator, counter and shifter to 0.
REQ-022 A reset asserted mid-operation SHALL abort the operation with no done pulse; the first start after reset deassertion SHALL behave normally.

Configuration
REQ-023 Macro SEQ_MULT_EARLY_EXIT_EN SHALL control early termination.
- Defined: in RUN, if the remaining unshifted multiplier bits are all 0, go to DONE on the next edge. Latency becomes 2 + (index of the highest set bit of b) + 1 cycles, with a minimum of 3 (b=0 gives 3).
- Undefined: latency is always WIDTH+2.
- product SHALL be identical in both cases.

Structure
REQ-024 A shared package seq_mult_pkg SHALL hold:
- the state enum (IDLE, LOAD, RUN, DONE);
- the default WIDTH constant.
REQ-025 The serial shifter SHALL be a separate sub-module, mult_piso_shift, with ports clk, reset, sl (1=load, 0=shift), d[WIDTH] and q (serial out, LSB first).
REQ-026 The counter width SHALL be $clog2(WIDTH), with a minimum of 1.

Verification
REQ-027 WIDTH=4, a=9, b=11, start pulse: busy rises the next cycle; done is seen at cycle 6 with product=99.
REQ-028 a=15, b=15: product=225; a=0, b=13: product=0; b=0 with the macro defined: done at cycle 3, product=0.
REQ-029 start re-pulsed during RUN with a=1, b=1: the in-flight result 9*11=99 is unchanged, with no second done.
REQ-030 reset driven low during RUN cycle 2: busy=0, done=0 and product=0 immediately; a new start with a=8, b=1 then gives product=8.
REQ-031 Back-to-back starts, with start held high continuously: operations complete every WIDTH+3 cycles, and each product matches the operands sampled on its accepting edge.
REQ-032 Random sweep of 200 operand pairs at WIDTH=4 and WIDTH=8, with the macro both on and off: every product equals a*b.
